spi_slave_mux: RTL
==================

# spi_slave_mux

FPGA-side SPI slave terminating the 32-bit host link. It deserializes MOSI frames of {index[3:0], data[27:0]} into a per-channel write strobe. In the same frame it serializes one outgoing word on MISO:
- the lowest-numbered pending channel, or
- the channel-0 status word when no channel has data pending.

It sits between the host SPI pins and the per-channel FIFOs and status logic of the yabot core.

## Interface
Parameters:
- NCH, 16: number of channels; index width is fixed at 4.
- DATA_W, 28: payload width; frame width is DATA_W+4 = 32.

Ports:
- clk  in  1  system clock; must be at least 6× the SPI clock (120 MHz for 20 MHz SPI).
- rst  in  1  asynchronous, active-high reset.
- spi_clk  in  1  SPI clock from host; idle low.
- spi_mosi  in  1  host data, MSB first.
- spi_cs  in  1  chip select, active low.
- spi_miso  out  1  slave data, MSB first.
- rx_valid  out  1  one-cycle pulse; a complete frame was received.
- rx_index  out  4  channel index of the received frame.
- rx_data  out  28  payload of the received frame.
- tx_valid  in  NCH  per-channel "word pending".
- tx_data  in  NCH*28  flattened per-channel words; channel i occupies [28*i +: 28].
- tx_ready  out  NCH  one-cycle pulse; the word on channel i has been consumed.
- status_in  in  28  channel-0 shadow status, sent when nothing is pending.
- frame_err  out  1  one-cycle pulse; a frame ended with a bit count other than 32.

## Operation
- spi_clk, spi_mosi and spi_cs each pass through a 2-FF synchronizer, followed by edge detection.
- FSM states:
  - IDLE: entered on reset and on CS rise.
  - ARM: entered on CS fall.
  - SHIFT: active until CS rise.
- On CS fall (ARM):
  - Priority-select the lowest i with tx_valid[i]=1.
  - Latch sel_idx and sel_hit.
  - Load tx_shift = {i, tx_data[i]}, or {4'h0, status_in} when no channel is valid.
  - Clear the bit counter.
- On a synchronized spi_clk rising edge in SHIFT:
  - rx_shift <= {rx_shift[30:0], mosi}.
  - Increment the bit counter, saturating at 33.
- On a synchronized spi_clk falling edge in SHIFT: tx_shift <= tx_shift << 1.
- spi_miso = tx_shift[31] whenever spi_cs is low; 0 otherwise.
- On CS rise:
  - Bit count == 32:
    - Pulse rx_valid with rx_index = rx_shift[31:28] and rx_data = rx_shift[27:0].
    - If sel_hit, pulse tx_ready[sel_idx].
  - Any other bit count: pulse frame_err only. No rx_valid, no tx_ready, so the pending word is resent in the next frame.
- tx_valid and tx_data are sampled only at CS fall. Later changes within the frame have no effect.
- status_in is likewise captured at CS fall. The host keeps its own shadow copy.
- A clock edge seen while in IDLE (CS high) is ignored.
- A CS fall seen during SHIFT cannot happen without a CS rise first; if it does, treat it as a fresh ARM.

## Timing
- Reset values:
  - spi_miso = 0, rx_valid = 0, rx_index = 0, rx_data = 0, tx_ready = 0, frame_err = 0.
  - Both shift registers = 0; FSM = IDLE.
- Edge-to-action latency is 3 clk cycles (2 synchronizer stages plus 1 edge-detect register).
- The first MISO bit is valid 3 clk cycles after CS falls. The host's first rising edge comes ≥50 ns later.
- MISO updates 3 clk cycles after spi_clk falls. It must be stable before the host samples at the end of the next high phase (25 ns later).
- rx_valid, tx_ready and frame_err all pulse in the same cycle, 3 clk cycles after CS rises.
- Reset asserted mid-frame:
  - Everything returns to its reset value.
  - No pulses are emitted.
  - The host frame is lost and the pending word is kept.

## Structure
- Package spi_link_pkg:
  - FRAME_W = 32, IDX_W = 4, DATA_W = 28.
  - Frame field slices.
  - STATUS_IDX = 0.
- Sub-module spi_sync_edge: 2-FF synchronizer plus rise/fall pulse outputs. Instantiated three times.

## Test plan
- Host sends 0x31234567 → rx_valid pulses once; rx_index = 3, rx_data = 0x1234567.
- tx_valid[5] = 1 with tx_data[5] = 0xABCDEF0 → host receives 0x5ABCDEF0; tx_ready[5] pulses once after CS rise.
- No tx_valid, status_in = 0x0000042 → host receives 0x00000042; no tx_ready pulse.
- tx_valid[2] and tx_valid[7] both set → first frame returns index 2, second frame returns index 7, third frame returns status.
- CS raised after 10 clocks with tx_valid[4] set → frame_err pulses; no rx_valid or tx_ready. The next full frame returns the channel-4 word.
- rst pulsed at bit 16 of a frame → all outputs 0, no pulses. A following full frame works normally.

Source files
------------

// File: rtl/spi_link_pkg.sv
// Shared constants, frame field helpers and FSM state type for the host SPI link.
package spi_link_pkg;

  localparam int FRAME_W = 32;
  localparam int IDX_W   = 4;
  localparam int DATA_W  = 28;
  localparam int CNT_W   = 6;

  localparam logic [IDX_W-1:0] STATUS_IDX = '0;
  localparam logic [CNT_W-1:0] CNT_SAT    = 6'd33;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_SHIFT
  } state_t;

  function automatic logic [IDX_W-1:0] frame_idx(input logic [FRAME_W-1:0] f);
    return f[FRAME_W-1 -: IDX_W];
  endfunction

  function automatic logic [DATA_W-1:0] frame_data(input logic [FRAME_W-1:0] f);
    return f[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-stage synchronizer for one SPI pin plus a registered copy for edge detection.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // NOTE: flops are assigned with <= so every stage samples the previous stage's old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Edges act on the cycle s3 catches up, so level and actions change together.
  assign level = s3;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/spi_slave_mux.sv
// SPI slave: receives {index, data} frames and returns the lowest pending channel word or status.
module spi_slave_mux #(
  parameter int NCH    = 16,
  parameter int DATA_W = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_clk,
  input  logic                  spi_mosi,
  input  logic                  spi_cs,
  output logic                  spi_miso,
  output logic                  rx_valid,
  output logic [3:0]            rx_index,
  output logic [DATA_W-1:0]     rx_data,
  input  logic [NCH-1:0]        tx_valid,
  input  logic [NCH*DATA_W-1:0] tx_data,
  output logic [NCH-1:0]        tx_ready,
  input  logic [DATA_W-1:0]     status_in,
  output logic                  frame_err
);
  import spi_link_pkg::*;

  localparam int FW = DATA_W + IDX_W;

  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic cs_lvl, cs_rise, cs_fall;

  spi_sync_edge u_sync_sck  (.clk(clk), .rst(rst), .din(spi_clk),
                             .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge u_sync_mosi (.clk(clk), .rst(rst), .din(spi_mosi),
                             .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));
  spi_sync_edge u_sync_cs   (.clk(clk), .rst(rst), .din(spi_cs),
                             .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));

  logic unused_sync;
  assign unused_sync = &{1'b0, sck_lvl, mosi_rise, mosi_fall};

  state_t state, state_n;
  logic   do_load, do_end, do_rx, do_tx;

  logic [IDX_W-1:0] sel_idx, pick_idx;
  logic             sel_hit, pick_hit;
  logic [DATA_W-1:0] pick_word;
  logic [FW-1:0]    tx_shift, rx_shift;
  logic [CNT_W-1:0] bit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // A chip-select fall always re-arms, even mid-frame.
  always_comb begin
    state_n = state;
    if (cs_fall)                state_n = ST_ARM;
    else if (cs_rise)           state_n = ST_IDLE;
    else if (state == ST_ARM)   state_n = ST_SHIFT;
  end

  always_comb begin
    do_load = cs_fall;
    do_end  = cs_rise && (state != ST_IDLE);
    do_rx   = sck_rise && (state == ST_SHIFT);
    do_tx   = sck_fall && (state == ST_SHIFT);
  end

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    pick_idx  = STATUS_IDX;
    pick_hit  = 1'b0;
    pick_word = status_in;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (tx_valid[i]) begin
        pick_idx  = IDX_W'(i);
        pick_hit  = 1'b1;
        pick_word = tx_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_idx  <= '0;
      sel_hit  <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else if (do_load) begin
      sel_idx  <= pick_idx;
      sel_hit  <= pick_hit;
      tx_shift <= {pick_idx, pick_word};
      bit_cnt  <= '0;
    end else begin
      if (do_tx) tx_shift <= tx_shift << 1;
      if (do_rx) begin
        rx_shift <= {rx_shift[FW-2:0], mosi_lvl};
        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Only a frame of exactly FW bits is delivered and consumes the pending word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid  <= 1'b0;
      rx_index  <= '0;
      rx_data   <= '0;
      tx_ready  <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      tx_ready  <= '0;
      frame_err <= 1'b0;
      if (do_end) begin
        if (bit_cnt == CNT_W'(FW)) begin
          rx_valid <= 1'b1;
          rx_index <= rx_shift[FW-1 -: IDX_W];
          rx_data  <= rx_shift[DATA_W-1:0];
          if (sel_hit) tx_ready[sel_idx] <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

  assign spi_miso = ~cs_lvl & tx_shift[FW-1];

endmodule
